clk_div: RTL and testbench

- Integer clock divider running on the reference clock.
- Its reset input is the deassertion-synchronized reset produced by the reset synchronizer stage for this domain.
- Generates the UART TX/RX baud-tick clock from the reference clock, with a runtime-programmable ratio, even and odd division, and bypass for ratio 0/1 or when disabled.

---
 rtl/clk_div.sv | 100 ++++++++++
 tb/tb_clk_div.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/clk_div.sv
// ---------------------------------------------------------------------------
// clk_div
//   Integer clock divider on the reference clock. It generates the UART
//   TX/RX baud-tick clock. The ratio can be changed at run time, and both
//   even and odd ratios are supported. The block bypasses (output follows
//   the reference clock) when disabled or when the latched ratio is 0 or 1.
//
//   Even ratio N : low N/2 cycles, high N/2 cycles.
//   Odd ratio N  : low (N+1)/2 cycles, high (N-1)/2 cycles.
//
// Ports
//   CLKDIV_CLK   in  1         reference clock, all state updates on rising edge
//   CLKDIV_RST   in  1         asynchronous active-low reset (synchronizer output)
//   CLKDIV_EN    in  1         divider enable
//   CLKDIV_RATIO in  RATIO_WD  division ratio N
//   CLKDIV_OUT   out 1         divided clock, or CLKDIV_CLK in bypass
// ---------------------------------------------------------------------------
module clk_div #(
  parameter int RATIO_WD = 8
) (
  input  logic                CLKDIV_CLK,
  input  logic                CLKDIV_RST,
  input  logic                CLKDIV_EN,
  input  logic [RATIO_WD-1:0] CLKDIV_RATIO,
  output logic                CLKDIV_OUT
);

  localparam int CNT_WD = RATIO_WD - 1;
  localparam logic [CNT_WD-1:0] CNT_ONE = CNT_WD'(1);

  logic [RATIO_WD-1:0] ratio_q, ratio_d;
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic                div_q, div_d;
  logic                phase_q, phase_d;

  logic                active;
  logic [CNT_WD-1:0]   half;
  logic [CNT_WD-1:0]   low_len_m1;
  logic [CNT_WD-1:0]   high_len_m1;
  logic [CNT_WD-1:0]   len_m1;

  // A latched ratio of 2 or more means any bit above bit 0 is set.
  assign active = CLKDIV_EN && (ratio_q[RATIO_WD-1:1] != '0);

  // half = floor(N/2). An odd N gives the extra cycle to the low phase, so
  // low_len-1 = half for odd N and half-1 for even N. high_len-1 is
  // always half-1. Both values fit in CNT_WD bits, so the counter cannot
  // overflow for any ratio.
  assign half        = ratio_q[RATIO_WD-1:1];
  assign low_len_m1  = ratio_q[0] ? half : (half - CNT_ONE);
  assign high_len_m1 = half - CNT_ONE;
  assign len_m1      = phase_q ? high_len_m1 : low_len_m1;

  // The output mux is combinational. Disabling the divider therefore
  // switches to bypass immediately, without waiting for a clock edge.
  assign CLKDIV_OUT = active ? div_q : CLKDIV_CLK;

  // Next-state logic. While idle or bypassed, the block tracks the ratio
  // input and holds the phase state at the start of a low phase. While
  // dividing, a new ratio is only accepted at the high->low boundary,
  // which keeps the current period from being shortened.
  always_comb begin
    ratio_d = ratio_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    phase_d = phase_q;
    if (!active) begin
      ratio_d = CLKDIV_RATIO;
      cnt_d   = '0;
      div_d   = 1'b0;
      phase_d = 1'b0;
    end else if (cnt_q == len_m1) begin
      cnt_d   = '0;
      div_d   = ~div_q;
      phase_d = ~phase_q;
      if (phase_q) begin
        ratio_d = CLKDIV_RATIO;
      end
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers. Reset clears the latched ratio to 0, which puts the
  // output in bypass for as long as reset is held.
  always_ff @(posedge CLKDIV_CLK or negedge CLKDIV_RST) begin
    if (!CLKDIV_RST) begin
      ratio_q <= '0;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      ratio_q <= ratio_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: tb/tb_clk_div.sv
// ---------------------------------------------------------------------------
// tb_clk_div
//   Self-checking bench for clk_div. The reference model describes the
//   divider as a position within the period: it keeps the ratio in use
//   and the number of input cycles since the period began. The output is
//   high once that position reaches the low-phase length. The ratio in use
//   is reloaded while not dividing and when the period wraps.
// ---------------------------------------------------------------------------
module tb_clk_div;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] ratio;
  logic       div_out;

  int compared   = 0;
  int mismatched = 0;

  int m_ratio = 0;
  int m_pos   = 0;

  clk_div #(.RATIO_WD(8)) dut (
    .CLKDIV_CLK  (clk),
    .CLKDIV_RST  (rst_n),
    .CLKDIV_EN   (en),
    .CLKDIV_RATIO(ratio),
    .CLKDIV_OUT  (div_out)
  );

  // Free-running reference clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the period position advances once per rising edge
  // while dividing. When it reaches the ratio in use, the period ends and
  // the next ratio is picked up.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ratio <= 0;
      m_pos   <= 0;
    end else if (!(en && m_ratio >= 2)) begin
      m_ratio <= int'(ratio);
      m_pos   <= 0;
    end else if (m_pos + 1 == m_ratio) begin
      m_ratio <= int'(ratio);
      m_pos   <= 0;
    end else begin
      m_pos <= m_pos + 1;
    end
  end

  function automatic logic modelActive();
    return en && (m_ratio >= 2);
  endfunction

  function automatic logic modelHigh();
    return m_pos >= (m_ratio + 1) / 2;
  endfunction

  function automatic logic expOut();
    return modelActive() ? modelHigh() : clk;
  endfunction

  // Every comparison goes through this task.
  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Runs n clock cycles and checks the output in both clock phases.
  task automatic runCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 checkOutput(tag, div_out, expOut());
      @(negedge clk);
      #1 checkOutput(tag, div_out, expOut());
    end
  endtask

  // Changes the inputs and checks that the combinational path reacts at once.
  task automatic applyStimulus(input logic e, input logic [7:0] r, input string tag);
    en    = e;
    ratio = r;
    #1 checkOutput(tag, div_out, expOut());
  endtask

  // Hard stop in case the bench ever stalls.
  initial begin
    #5000000;
    $display("[TB] FAIL timeout: observed stall expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] r;
    logic       e;
    int         waited;
    rst_n = 1'b0;
    en    = 1'b1;
    ratio = 8'd4;

    $display("[TB] reset held with EN=1 RATIO=4");
    runCycles(5, "reset_bypass");
    rst_n = 1'b1;
    runCycles(42, "ratio4");

    $display("[TB] ratio 5");
    applyStimulus(1'b1, 8'd5, "ratio5_apply");
    runCycles(55, "ratio5");

    $display("[TB] ratio 1 then 0");
    applyStimulus(1'b1, 8'd1, "ratio1_apply");
    runCycles(15, "ratio1");
    applyStimulus(1'b1, 8'd0, "ratio0_apply");
    runCycles(10, "ratio0");

    $display("[TB] ratio 8 changed to 3 in high phase");
    applyStimulus(1'b1, 8'd8, "ratio8_apply");
    runCycles(10, "ratio8");
    waited = 0;
    while (!(m_ratio == 8 && modelHigh() && m_pos == 5) && waited < 50) begin
      runCycles(1, "ratio8_wait");
      waited++;
    end
    checkOutput("ratio8_reached_high", modelHigh(), 1'b1);
    applyStimulus(1'b1, 8'd3, "ratio8to3_apply");
    runCycles(20, "ratio8to3");

    $display("[TB] ratio 6 with one-cycle disable");
    applyStimulus(1'b1, 8'd6, "ratio6_apply");
    runCycles(12, "ratio6");
    waited = 0;
    while (!(m_ratio == 6 && m_pos == 1) && waited < 50) begin
      runCycles(1, "ratio6_wait");
      waited++;
    end
    checkOutput("ratio6_reached_low", modelHigh(), 1'b0);
    applyStimulus(1'b0, 8'd6, "disable_bypass");
    runCycles(1, "disabled");
    applyStimulus(1'b1, 8'd6, "reenable");
    runCycles(30, "ratio6_restart");

    $display("[TB] ratio 255 then reset in high phase");
    applyStimulus(1'b1, 8'd255, "ratio255_apply");
    runCycles(520, "ratio255");
    waited = 0;
    while (!(m_ratio == 255 && modelHigh() && m_pos > 130) && waited < 300) begin
      runCycles(1, "ratio255_wait");
      waited++;
    end
    checkOutput("ratio255_reached_high", div_out, 1'b1);
    rst_n = 1'b0;
    #1 checkOutput("reset_mid_bypass", div_out, clk);
    runCycles(3, "reset_mid_held");
    rst_n = 1'b1;
    runCycles(300, "ratio255_restart");

    $display("[TB] randomized ratios and enables");
    for (int k = 0; k < 150; k++) begin
      e = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255));
      else                           r = 8'($urandom_range(0, 12));
      applyStimulus(e, r, "rand_apply");
      runCycles($urandom_range(1, 25), "rand_run");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
